cmp_wide_seq: RTL and testbench
===============================

Name:
cmp_wide_seq

Overview:
- Sequential wide magnitude comparator that walks two WIDTH-bit operands one 4-bit nibble at a time, MSB nibble first.
- Each step applies 4-bit lt/eq/gt logic to the current nibble pair and merges it with the running result, the same cascade rule used when combining narrower compare slices.
- It stops early at the first unequal nibble.
- Sits downstream of the 4-bit compare slice; consumers read a registered lt/eq/gt verdict plus a one-cycle done strobe.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 4.
- NIB, WIDTH/4, derived; number of nibbles; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request a comparison; sampled on the rising edge of clk
- x  input  WIDTH  operand A; captured when start is accepted
- y  input  WIDTH  operand B; captured when start is accepted
- busy  output  1  high while a comparison is in progress
- done  output  1  one-cycle pulse; the verdict is valid from this cycle onward
- lt  output  1  registered verdict: x < y (unsigned)
- eq  output  1  registered verdict: x == y
- gt  output  1  registered verdict: x > y (unsigned)
- steps  output  clog2(NIB)+1  number of nibbles examined for the last verdict (1..NIB)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, done, lt, eq, gt and steps all go to 0.
  - Operand registers and nibble index go to 0.
  - Reset asserted during CMP aborts the comparison; no done pulse follows.
- States: IDLE, CMP, DONE.
- IDLE, start=1 at edge t:
  - Capture x and y into internal registers.
  - Set idx to NIB-1, steps to 0, busy to 1.
  - Clear lt, eq and gt to 0.
  - Go to CMP.
- CMP, each edge, compare nibble idx of the captured operands (bits 4*idx+3 .. 4*idx). steps increments by 1 every CMP edge.
  - Nibble A < nibble B: lt=1, go to DONE.
  - Nibble A > nibble B: gt=1, go to DONE.
  - Nibbles equal and idx==0: eq=1, go to DONE.
  - Nibbles equal and idx>0: decrement idx, stay in CMP.
- Transition into DONE: busy falls to 0 and done rises to 1 on the same edge.
- DONE (exactly one cycle):
  - done=1; lt/eq/gt hold the verdict.
  - start=1: accepted exactly as in IDLE (back-to-back operation, no idle gap); done falls on the following edge.
  - start=0: go to IDLE with done=0.
  - Verdict is held in IDLE until the next accepted start.
- Latency: start accepted at edge t; the verdict is decided at edge t+m, with m = steps = 1 + number of leading equal nibble pairs, capped at NIB. done is high during the cycle after edge t+m. Worst case is m=NIB, i.e. 4 edges after accept for WIDTH=16.
- start while in CMP (busy=1) is ignored; x and y may change freely after the accept edge without affecting the result.
- Invariants:
  - When done=1 or after any completed comparison, exactly one of lt/eq/gt is 1.
  - During busy and after reset, all three are 0.
  - busy and done are never high together.
- Comparison is unsigned. For WIDTH=4, NIB=1, every comparison completes in 1 step.

Test Plan:
- Reset mid-run: start with x=16'h1234, y=16'h1235; assert rst after 2 CMP edges -> outputs go to 0 at once, no done pulse; after release, the same start completes normally with lt=1, steps=4.
- Early exit: x=16'hA000, y=16'h5FFF -> gt=1, steps=1, done one cycle after the accept edge; busy high for exactly 1 cycle.
- Full walk equal: x=y=16'hBEEF -> eq=1, steps=4, done 4 edges after accept.
- Low-nibble decision: x=16'h00F3, y=16'h00F7 -> lt=1, steps=4; x=16'h0300, y=16'h0200 -> gt=1, steps=2.
- Back-to-back and ignored start:
  - Hold start high through DONE with a new pair x=0, y=16'hFFFF -> second run accepted with no idle cycle, giving lt=1, steps=1.
  - Pulse start during CMP -> ignored.
  - Change x/y after accept -> result unaffected.
- Exhaustive, WIDTH=4 build: all 256 (x,y) pairs -> each verdict matches the reference model, exactly one flag set, steps=1.

Source files
------------

// File: rtl/cmp_wide_seq.sv
// Sequential unsigned magnitude comparator: walks x/y one nibble per cycle, MSB nibble first, exits at first difference.
// Latency: verdict registered m edges after accept (m = 1 + leading equal nibbles, max NIB); done pulses the cycle after.
// Backpressure: start is ignored while busy; a start during the one-cycle DONE state is accepted back-to-back.
module cmp_wide_seq #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       x,
  input  logic [WIDTH-1:0]       y,
  output logic                   busy,
  output logic                   done,
  output logic                   lt,
  output logic                   eq,
  output logic                   gt,
  output logic [$clog2(NIB):0]   steps
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int SW = $clog2(NIB) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             last_nib;

  // Select the nibble pair currently under examination from the captured operands
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        nib_a = xr[4*i +: 4];
        nib_b = yr[4*i +: 4];
      end
    end
    last_nib = (idx == '0);
  end

  // Control FSM plus registered verdict; IDLE and DONE share the accept path so DONE can restart with no gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      xr    <= '0;
      yr    <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      steps <= '0;
    end else begin
      case (state)
        S_CMP: begin
          steps <= steps + 1'b1;
          if (nib_a < nib_b) begin
            lt    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (nib_a > nib_b) begin
            gt    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (last_nib) begin
            eq    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          // done is a single-cycle strobe; the verdict itself stays until the next accept
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            yr    <= y;
            idx   <= IW'(NIB - 1);
            steps <= '0;
            busy  <= 1'b1;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            state <= S_CMP;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_wide_seq.sv
// Directed bench for cmp_wide_seq: WIDTH=16 instance for sequencing cases, WIDTH=4 instance swept exhaustively.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on done is bounded; a global watchdog ends a hung run.
module tb_cmp_wide_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        busy, done, lt, eq, gt;
  logic [2:0]  steps;

  logic        start4;
  logic [3:0]  x4;
  logic [3:0]  y4;
  logic        busy4, done4, lt4, eq4, gt4;
  logic [0:0]  steps4;

  int n_assert = 0;
  int n_fail   = 0;

  cmp_wide_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt), .steps(steps)
  );

  cmp_wide_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gt(gt4), .steps(steps4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  // Present an operand pair with start for one rising edge; returns at the falling edge after accept
  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    x = a;
    y = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the falling edge after accept, wait for done and check latency, busy width and verdict
  task automatic finish_run(input string tag, input int m, input logic elt, input logic eeq, input logic egt);
    int k;
    int bc;
    bc = busy ? 1 : 0;
    check({tag, "_flags_busy"}, {29'd0, lt, eq, gt}, 32'd0);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (busy) bc++;
    end
    check({tag, "_latency"}, k, m);
    check({tag, "_busy_cycles"}, bc, m);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_verdict"}, {29'd0, lt, eq, gt}, {29'd0, elt, eeq, egt});
    check({tag, "_steps"}, {29'd0, steps}, m);
  endtask

  // One cycle after done: strobe gone, verdict held in IDLE
  task automatic hold_check(input string tag, input logic elt, input logic eeq, input logic egt, input int m);
    @(negedge clk);
    check({tag, "_hold_ctl"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold_verdict"}, {29'd0, lt, eq, gt}, {29'd0, elt, eeq, egt});
    check({tag, "_hold_steps"}, {29'd0, steps}, m);
  endtask

  initial begin
    bit seen_done;
    rst    = 1'b1;
    start  = 1'b0;
    x      = '0;
    y      = '0;
    start4 = 1'b0;
    x4     = '0;
    y4     = '0;

    // Reset state
    #2;
    check("reset_ctl", {30'd0, busy, done}, 32'd0);
    check("reset_flags", {29'd0, lt, eq, gt}, 32'd0);
    check("reset_steps", {29'd0, steps}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run: two CMP edges then asynchronous reset
    accept(16'h1234, 16'h1235);
    @(negedge clk);
    @(negedge clk);
    check("midrun_busy_before_rst", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrun_rst_ctl", {30'd0, busy, done}, 32'd0);
    check("midrun_rst_flags", {29'd0, lt, eq, gt}, 32'd0);
    check("midrun_rst_steps", {29'd0, steps}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("midrun_no_done", {31'd0, seen_done}, 32'd0);
    accept(16'h1234, 16'h1235);
    finish_run("midrun_rerun", 4, 1'b1, 1'b0, 1'b0);
    hold_check("midrun_rerun", 1'b1, 1'b0, 1'b0, 4);

    // Early exit on the top nibble
    accept(16'hA000, 16'h5FFF);
    finish_run("early_gt", 1, 1'b0, 1'b0, 1'b1);
    hold_check("early_gt", 1'b0, 1'b0, 1'b1, 1);

    // Full walk, equal operands
    accept(16'hBEEF, 16'hBEEF);
    finish_run("full_eq", 4, 1'b0, 1'b1, 1'b0);
    hold_check("full_eq", 1'b0, 1'b1, 1'b0, 4);

    // Decisions on lower nibbles
    accept(16'h00F3, 16'h00F7);
    finish_run("low_lt", 4, 1'b1, 1'b0, 1'b0);
    hold_check("low_lt", 1'b1, 1'b0, 1'b0, 4);
    accept(16'h0300, 16'h0200);
    finish_run("nib2_gt", 2, 1'b0, 1'b0, 1'b1);
    hold_check("nib2_gt", 1'b0, 1'b0, 1'b1, 2);

    // Start pulsed during CMP with new operands: ignored, captured pair still decides
    accept(16'h7777, 16'h7777);
    x = 16'h0000;
    y = 16'hFFFF;
    start = 1'b1;
    finish_run("ignored_start", 4, 1'b0, 1'b1, 1'b0);

    // Back-to-back: start presented during DONE is accepted with no idle cycle
    x = 16'h0000;
    y = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept_ctl", {30'd0, busy, done}, 32'd2);
    check("b2b_accept_steps", {29'd0, steps}, 32'd0);
    x = 16'hFFFF;
    y = 16'h0000;
    finish_run("b2b", 1, 1'b1, 1'b0, 1'b0);
    hold_check("b2b", 1'b1, 1'b0, 1'b0, 1);

    // Exhaustive sweep on the 4-bit build
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        x4 = 4'(a);
        y4 = 4'(b);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        x4 = ~x4;
        check("w4_busy", {30'd0, busy4, done4}, 32'd2);
        @(negedge clk);
        check($sformatf("w4_%0h_%0h", a, b),
              {26'd0, done4, busy4, lt4, eq4, gt4, steps4},
              {26'd0, 1'b1, 1'b0, (a < b), (a == b), (a > b), 1'b1});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
